// File: rtl/alu_definitions.sv
// ALU-side shared types: the operation class handed to the ALU-op decoder
// and the decoder's error flag type.
package alu_definitions;

    typedef logic flag_t;

    typedef enum logic [1:0] {
        TYPE_I  = 2'd0,
        TYPE_R  = 2'd1,
        DEF_ADD = 2'd2,
        PASS_S1 = 2'd3
    } aluOp_t;

endpackage

// File: rtl/definitions.sv
// Core control types: datapath mux selects, control FSM states and the
// RV32I major opcodes the control FSM dispatches on.
package definitions;

    typedef enum logic {
        PC_PLUS4 = 1'b0,
        PC_ALU   = 1'b1
    } pcSrc_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wbSel_t;

    typedef enum logic [1:0] {
        SRC_RS1 = 2'd0,
        SRC_PC  = 2'd1,
        SRC_IMM = 2'd2
    } srcA_t;

    // B-side literals carry their own prefix so they do not collide with
    // the A-side immediate select.
    typedef enum logic {
        SRC_B_RS2 = 1'b0,
        SRC_B_IMM = 1'b1
    } srcB_t;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_LUI_EX   = 4'd7,
        S_JUMP     = 4'd8,
        S_WB_ALU   = 4'd9,
        S_WB_MEM   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

endpackage

// File: rtl/mem_watchdog.sv
// Memory request timeout counter.
// Ports: start = request held this cycle, clear = leaving the state,
// expired = this is the TIMEOUT-th request cycle in the state.
module mem_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic clear,
    output logic expired
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    // count holds the request cycles already spent, so the current cycle
    // is the last allowed one when count == TIMEOUT-1. A memReady in
    // that same cycle still wins in the FSM.
    assign expired = start && (count >= CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (start && !expired) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/write-back.
// Ports: opcode/aluError/memReady in; memory, PC, regfile, ALU strobes,
// sticky trap, retired pulse and instret counter out.
module multicycle_control
    import definitions::*;
    import alu_definitions::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  flag_t                aluError,
    input  logic                 memReady,
    output logic                 memReq,
    output logic                 memWe,
    output logic                 irWrite,
    output logic                 pcWrite,
    output pcSrc_t               pcSrc,
    output logic                 regWrite,
    output wbSel_t               wbSel,
    output srcA_t                aluSrcA,
    output srcB_t                aluSrcB,
    output aluOp_t               aluOp,
    output logic                 trap,
    output logic                 retired,
    output logic [INSTRET_W-1:0] instret
);

    state_t state;
    state_t state_n;
    logic   wd_expired;

    mem_watchdog #(
        .TIMEOUT(MEM_TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (memReq),
        .clear  (state_n != state),
        .expired(wd_expired)
    );

    // Strobes are decoded from the current state; rst forces them all
    // low so a reset edge never coincides with a write or retirement.
    always_comb begin
        memReq   = 1'b0;
        memWe    = 1'b0;
        irWrite  = 1'b0;
        pcWrite  = 1'b0;
        pcSrc    = PC_PLUS4;
        regWrite = 1'b0;
        wbSel    = WB_ALU;
        aluSrcA  = SRC_PC;
        aluSrcB  = SRC_B_IMM;
        aluOp    = DEF_ADD;
        retired  = 1'b0;
        if (!rst) begin
            unique case (state)
                S_FETCH: begin
                    memReq  = 1'b1;
                    irWrite = memReady;
                    pcWrite = memReady;
                end
                S_EXEC_R: begin
                    aluOp   = TYPE_R;
                    aluSrcA = SRC_RS1;
                    aluSrcB = SRC_B_RS2;
                end
                S_EXEC_I: begin
                    aluOp   = TYPE_I;
                    aluSrcA = SRC_RS1;
                end
                S_MEM_ADDR: begin
                    aluSrcA = SRC_RS1;
                end
                S_MEM_RD: begin
                    memReq = 1'b1;
                end
                S_MEM_WR: begin
                    memReq  = 1'b1;
                    memWe   = 1'b1;
                    retired = memReady;
                end
                S_LUI_EX: begin
                    aluOp   = PASS_S1;
                    aluSrcA = SRC_IMM;
                end
                S_JUMP: begin
                    pcWrite  = 1'b1;
                    pcSrc    = PC_ALU;
                    regWrite = 1'b1;
                    wbSel    = WB_PC4;
                    retired  = 1'b1;
                end
                S_WB_ALU: begin
                    regWrite = 1'b1;
                    retired  = 1'b1;
                end
                S_WB_MEM: begin
                    regWrite = 1'b1;
                    wbSel    = WB_MEM;
                    retired  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_FETCH: begin
                if (memReady)        state_n = S_DECODE;
                else if (wd_expired) state_n = S_TRAP;
            end
            S_DECODE: begin
                unique case (1'b1)
                    opcode == OP_R:     state_n = S_EXEC_R;
                    opcode == OP_I:     state_n = S_EXEC_I;
                    opcode == OP_LOAD,
                    opcode == OP_STORE: state_n = S_MEM_ADDR;
                    opcode == OP_LUI:   state_n = S_LUI_EX;
                    opcode == OP_JAL:   state_n = S_JUMP;
                    default:            state_n = S_TRAP;
                endcase
            end
            S_EXEC_R,
            S_EXEC_I: begin
                state_n = aluError ? S_TRAP : S_WB_ALU;
            end
            S_MEM_ADDR: begin
                // opcode[5] separates store (0100011) from load (0000011)
                state_n = opcode[5] ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                if (memReady)        state_n = S_WB_MEM;
                else if (wd_expired) state_n = S_TRAP;
            end
            S_MEM_WR: begin
                if (memReady)        state_n = S_FETCH;
                else if (wd_expired) state_n = S_TRAP;
            end
            S_LUI_EX: state_n = S_WB_ALU;
            S_JUMP,
            S_WB_ALU,
            S_WB_MEM: state_n = S_FETCH;
            S_TRAP:   state_n = S_TRAP;
            default:  state_n = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            trap    <= 1'b0;
            instret <= '0;
        end else begin
            state <= state_n;
            trap  <= (state_n == S_TRAP);
            if (retired) begin
                instret <= instret + INSTRET_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: driver pushes expected
// retire/trap events, negedge monitor pops and compares them.
module tb_multicycle_control;
    import definitions::*;
    import alu_definitions::*;

    localparam int TO = 4;
    localparam int IW = 4;

    localparam int C_R   = 0;
    localparam int C_I   = 1;
    localparam int C_LD  = 2;
    localparam int C_ST  = 3;
    localparam int C_LUI = 4;
    localparam int C_JAL = 5;
    localparam int C_BAD = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = '0;
    flag_t         aluError = 1'b0;
    logic          memReady = 1'b0;
    logic          memReq, memWe, irWrite, pcWrite, regWrite;
    pcSrc_t        pcSrc;
    wbSel_t        wbSel;
    srcA_t         aluSrcA;
    srcB_t         aluSrcB;
    aluOp_t        aluOp;
    logic          trap, retired;
    logic [IW-1:0] instret;

    multicycle_control #(
        .MEM_TIMEOUT(TO),
        .INSTRET_W  (IW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .aluError(aluError),
        .memReady(memReady),
        .memReq  (memReq),
        .memWe   (memWe),
        .irWrite (irWrite),
        .pcWrite (pcWrite),
        .pcSrc   (pcSrc),
        .regWrite(regWrite),
        .wbSel   (wbSel),
        .aluSrcA (aluSrcA),
        .aluSrcB (aluSrcB),
        .aluOp   (aluOp),
        .trap    (trap),
        .retired (retired),
        .instret (instret)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit is_trap;
        bit reg_write;
        int wb_sel;
        bit pc_write;
        int pc_src;
        bit mem_we;
        int instret;
        int alu_chk;
        int alu_op;
        int src_a;
        int src_b;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         model_instret = 0;
    logic [6:0] next_bad = 7'b1111111;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic logic [6:0] illegal_op();
        logic [6:0] o;
        do begin
            o = 7'($urandom);
        end while (o == 7'b0110011 || o == 7'b0010011 ||
                   o == 7'b0000011 || o == 7'b0100011 ||
                   o == 7'b0110111 || o == 7'b1101111);
        return o;
    endfunction

    // One instruction: latency from class and wait counts, expected
    // event queued up front, then the per-cycle inputs are played out.
    task automatic run_instr(input int cls, input int fw, input int dw,
                             input bit err, input bit rst_wb);
        logic [6:0] op;
        exp_t e;
        int dr, ex, ev, tr, total, base, rst_t;
        dr = -1; ex = -1; ev = -1; tr = -1; rst_t = -1;
        case (cls)
            C_R:     op = 7'b0110011;
            C_I:     op = 7'b0010011;
            C_LD:    op = 7'b0000011;
            C_ST:    op = 7'b0100011;
            C_LUI:   op = 7'b0110111;
            C_JAL:   op = 7'b1101111;
            default: begin op = next_bad; next_bad = illegal_op(); end
        endcase
        if (fw >= TO) begin
            tr = TO;
        end else begin
            case (cls)
                C_R, C_I: begin
                    ex = fw + 2;
                    if (err) tr = fw + 3; else ev = fw + 3;
                end
                C_LUI: ev = fw + 3;
                C_LD: begin
                    if (dw >= TO) tr = fw + 3 + TO;
                    else begin dr = fw + 3 + dw; ev = fw + dw + 4; end
                end
                C_ST: begin
                    if (dw >= TO) tr = fw + 3 + TO;
                    else begin dr = fw + 3 + dw; ev = fw + dw + 3; end
                end
                C_JAL:   ev = fw + 2;
                default: tr = fw + 2;
            endcase
        end
        e = '{default: 0};
        base = cyc;
        e.instret = model_instret;
        if (tr >= 0) begin
            e.cyc = base + tr;
            e.is_trap = 1'b1;
            sb.push_back(e);
        end else if (rst_wb) begin
            rst_t = ev;
        end else begin
            e.cyc       = base + ev;
            e.reg_write = (cls != C_ST);
            e.wb_sel    = (cls == C_LD)  ? int'(WB_MEM) :
                          (cls == C_JAL) ? int'(WB_PC4) : int'(WB_ALU);
            e.pc_write  = (cls == C_JAL);
            e.pc_src    = (cls == C_JAL) ? int'(PC_ALU) : int'(PC_PLUS4);
            e.mem_we    = (cls == C_ST);
            case (cls)
                C_R: begin
                    e.alu_chk = 1; e.alu_op = int'(TYPE_R);
                    e.src_a = int'(SRC_RS1); e.src_b = int'(SRC_B_RS2);
                end
                C_I: begin
                    e.alu_chk = 1; e.alu_op = int'(TYPE_I);
                    e.src_a = int'(SRC_RS1); e.src_b = int'(SRC_B_IMM);
                end
                C_LUI: begin
                    e.alu_chk = 1; e.alu_op = int'(PASS_S1);
                    e.src_a = int'(SRC_IMM); e.src_b = int'(SRC_B_IMM);
                end
                C_JAL: begin
                    e.alu_chk = 2; e.alu_op = int'(DEF_ADD);
                    e.src_a = int'(SRC_PC); e.src_b = int'(SRC_B_IMM);
                end
                default: e.alu_chk = 0;
            endcase
            sb.push_back(e);
            model_instret = (model_instret + 1) % (1 << IW);
        end
        total = (tr >= 0) ? tr + 3 : ev + 1;
        for (int t = 0; t < total; t++) begin
            opcode   = op;
            memReady = (t == fw) || (t == dr);
            aluError = (t == ex) ? err :
                       (t == fw + 1) ? 1'b1 : 1'($urandom_range(0, 1));
            rst      = (t == rst_t);
            if (t == 0) begin
                @(negedge clk);
                check("start_memReq", int'(memReq), 1);
                check("start_trap", int'(trap), 0);
                check("start_instret", int'(instret), e.instret);
            end
            @(posedge clk);
            #1;
        end
        if (tr >= 0) begin
            rst = 1'b1;
            memReady = 1'b1;
            @(posedge clk);
            #1;
        end
        if (tr >= 0 || rst_wb) model_instret = 0;
    endtask

    exp_t   mon_e;
    bit     p_trap = 1'b0;
    aluOp_t p_op;
    srcA_t  p_a;
    srcB_t  p_b;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_strobes",
                  int'({retired, regWrite, pcWrite, irWrite, memReq}), 0);
        end else begin
            if (trap) begin
                check("trap_quiet",
                      int'({memReq, regWrite, pcWrite, irWrite, retired}), 0);
            end
            if (retired || (trap && !p_trap)) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: retired=%0d trap=%0d cycle %0d",
                             retired, trap, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    check("event_cycle", cyc, mon_e.cyc);
                    check("event_kind", int'(trap), int'(mon_e.is_trap));
                    if (!mon_e.is_trap) begin
                        check("regWrite", int'(regWrite), int'(mon_e.reg_write));
                        if (mon_e.reg_write) check("wbSel", int'(wbSel), mon_e.wb_sel);
                        check("pcWrite", int'(pcWrite), int'(mon_e.pc_write));
                        if (mon_e.pc_write) check("pcSrc", int'(pcSrc), mon_e.pc_src);
                        check("memWe", int'(memWe), int'(mon_e.mem_we));
                        check("instret", int'(instret), mon_e.instret);
                        if (mon_e.alu_chk == 1) begin
                            check("exec_aluOp", int'(p_op), mon_e.alu_op);
                            check("exec_srcA", int'(p_a), mon_e.src_a);
                            check("exec_srcB", int'(p_b), mon_e.src_b);
                        end else if (mon_e.alu_chk == 2) begin
                            check("jal_aluOp", int'(aluOp), mon_e.alu_op);
                            check("jal_srcA", int'(aluSrcA), mon_e.src_a);
                            check("jal_srcB", int'(aluSrcB), mon_e.src_b);
                        end
                    end
                end
            end
        end
        p_trap = trap;
        p_op   = aluOp;
        p_a    = aluSrcA;
        p_b    = aluSrcB;
    end

    initial begin
        int cls, r, fw, dw;
        bit err;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        run_instr(C_R,   0, 0, 1'b0, 1'b0);
        run_instr(C_LD,  0, 3, 1'b0, 1'b0);
        run_instr(C_BAD, 0, 0, 1'b0, 1'b0);
        run_instr(C_I,   0, 0, 1'b1, 1'b0);
        run_instr(C_I,   1, 0, 1'b0, 1'b0);
        run_instr(C_R,   TO, 0, 1'b0, 1'b0);
        run_instr(C_R,   TO - 1, 0, 1'b0, 1'b0);
        run_instr(C_ST,  0, 0, 1'b0, 1'b0);
        run_instr(C_ST,  2, TO, 1'b0, 1'b0);
        run_instr(C_JAL, 0, 0, 1'b0, 1'b0);
        run_instr(C_LUI, 0, 0, 1'b0, 1'b0);
        run_instr(C_LD,  0, TO - 1, 1'b0, 1'b0);
        run_instr(C_R,   0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 17; i++) run_instr(C_R, 0, 0, 1'b0, 1'b0);
        run_instr(C_R,   0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            cls = (($urandom_range(0, 15)) == 0) ? C_BAD : $urandom_range(0, 5);
            r   = $urandom_range(0, 11);
            fw  = (r == 11) ? TO : r % TO;
            r   = $urandom_range(0, 9);
            dw  = (r == 9) ? TO : r % TO;
            err = ($urandom_range(0, 7) == 0);
            run_instr(cls, fw, dw, err, 1'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the RV32I core, directly upstream of the ALU-operation decoder. It sequences fetch, decode, execute, memory and write-back for each instruction and drives the datapath strobes. It supplies the `aluOp` class that the decoder turns into an ALU operation select, and it converts decoder errors into a trap.

## Interface
Parameters:
- `MEM_TIMEOUT`, 255: maximum number of cycles `memReq` stays asserted without `memReady` before a trap.
- `INSTRET_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  single core clock; everything is on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `opcode`  in  7  instruction bits [6:0], taken from the instruction register.
- `aluError`  in  1  `flag_t` error output of the ALU-operation decoder.
- `memReady`  in  1  memory completes the current request this cycle.
- `memReq`  out  1  memory request.
- `memWe`  out  1  write qualifier for `memReq`.
- `irWrite`  out  1  load the instruction register.
- `pcWrite`  out  1  update the PC.
- `pcSrc`  out  `pcSrc_t`  PC_PLUS4 or PC_ALU.
- `regWrite`  out  1  register-file write enable.
- `wbSel`  out  `wbSel_t`  WB_ALU, WB_MEM or WB_PC4.
- `aluSrcA`  out  `srcA_t`  SRC_RS1, SRC_PC or SRC_IMM.
- `aluSrcB`  out  `srcB_t`  SRC_RS2 or SRC_IMM.
- `aluOp`  out  `aluOp_t`  TYPE_I, TYPE_R, DEF_ADD or PASS_S1.
- `trap`  out  1  sticky fault indication.
- `retired`  out  1  one-cycle pulse when an instruction completes.
- `instret`  out  `INSTRET_W`  count of retired instructions.

## Operation
- **States:** FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, LUI_EX, JUMP, WB_ALU, WB_MEM, TRAP.
- **FETCH**
  - Drives `memReq`=1 and `memWe`=0.
  - On `memReady`: `irWrite`=1, `pcWrite`=1 with `pcSrc`=PC_PLUS4, then go to DECODE.
  - Without `memReady`: stay in FETCH.
- **DECODE:** one cycle, no strobes. Dispatch on `opcode`:
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0000011 or 0100011 -> MEM_ADDR
  - 0110111 -> LUI_EX
  - 1101111 -> JUMP
  - any other value -> TRAP
- **EXEC_R:** `aluOp`=TYPE_R, `aluSrcA`=SRC_RS1, `aluSrcB`=SRC_RS2.
- **EXEC_I:** `aluOp`=TYPE_I, `aluSrcA`=SRC_RS1, `aluSrcB`=SRC_IMM.
- **After EXEC_R or EXEC_I:** if `aluError`=1, go to TRAP; otherwise go to WB_ALU.
- **MEM_ADDR:** `aluOp`=DEF_ADD, `aluSrcA`=SRC_RS1, `aluSrcB`=SRC_IMM. Next state is MEM_RD for a load, MEM_WR for a store (selected by `opcode`[5]).
- **MEM_RD:** `memReq`=1 until `memReady`, then WB_MEM.
- **MEM_WR:** `memReq`=1 and `memWe`=1 until `memReady`. On `memReady`, pulse `retired` and go to FETCH.
- **LUI_EX:** `aluOp`=PASS_S1, `aluSrcA`=SRC_IMM, then WB_ALU.
- **JUMP**
  - Drives `aluOp`=DEF_ADD with `aluSrcA`=SRC_PC and `aluSrcB`=SRC_IMM.
  - Also drives `pcWrite`=1 with `pcSrc`=PC_ALU, `regWrite`=1 with `wbSel`=WB_PC4, and pulses `retired`.
  - Next state is FETCH.
- **WB_ALU / WB_MEM:** `regWrite`=1 with `wbSel` set to WB_ALU or WB_MEM respectively, pulse `retired`, then FETCH.
- **TRAP:** `trap`=1 and all strobes 0. Stays in TRAP until `rst`.
- **Idle defaults:** in any state that does not name them, `aluOp`=DEF_ADD, `aluSrcA`=SRC_PC and `aluSrcB`=SRC_IMM.
- **Memory watchdog:** counts the cycles `memReq` has been held in the current state. If the count reaches `MEM_TIMEOUT` without `memReady`, go to TRAP. The counter clears on state exit.
- **`instret`:** increments on each `retired` pulse and wraps from all-ones to 0.

## Timing
- **Reset:** `rst` sampled high at an edge gives state FETCH, watchdog 0, `instret` 0, `trap` 0.
  - All registered outputs are 0 after that edge.
  - Combinational strobes follow FETCH, so `memReq`=1 in the first cycle after reset.
  - Reset mid-operation abandons the instruction: no `regWrite` or `pcWrite` is issued afterwards.
- **Output timing:** all strobes are Moore outputs decoded from the current state. The exceptions are `irWrite`, `pcWrite` and `retired` in the handshake states, which are qualified combinationally by `memReady`.
- **`aluError`** is sampled only at the EXEC_R/EXEC_I edge and ignored in every other state.
- **Latency with zero-wait memory:**
  - R-type, I-type and LUI: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - JAL: 3 cycles.
  - Each memory wait cycle adds 1.
- **Watchdog boundary:** `memReady` arriving in the same cycle the count reaches `MEM_TIMEOUT` counts as success.
- **`rst` and `memReady` high together:** reset wins.

## Structure
- Add `pcSrc_t`, `wbSel_t`, `srcA_t`, `srcB_t`, the state enum and the opcode constants to `definitions`.
- `aluOp_t` remains in `alu_definitions`.
- One natural sub-module: `mem_watchdog`, the timeout counter with `start`, `clear`, `expired`.

## Test plan
- **R-type ADD (opcode 0110011), `memReady` always 1:** states go FETCH, DECODE, EXEC_R, WB_ALU. `aluOp`=TYPE_R in cycle 2, `regWrite`=1 in cycle 3, `instret`=1.
- **Load with `memReady` delayed 3 cycles in MEM_RD:** completes in 8 cycles, `wbSel`=WB_MEM, `retired` pulses once.
- **Opcode 1111111:** TRAP after DECODE with `trap`=1 and no further `memReq`. Asserting `rst` returns the FSM to FETCH.
- **EXEC_I with `aluError`=1:** TRAP with no `regWrite`. `aluError`=1 asserted during DECODE only has no effect.
- **`MEM_TIMEOUT`=4, `memReady` held 0 in FETCH:** TRAP after 4 request cycles. A second run with `memReady` high on the 4th cycle proceeds to DECODE.
- **`instret` preloaded via 2^`INSTRET_W`-1 retirements (use `INSTRET_W`=4):** the 16th retirement wraps `instret` to 0. `rst` during WB_ALU suppresses that `regWrite`.
